// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction-fetch stage of the RV32I single-cycle core.
//
// Owns the program counter and fetches one instruction at a time from
// instruction memory. The fetched word and its PC are held stable for the
// decode/control stage until it retires the instruction. The next PC is then
// computed from the control stage's PC-source select.
//
// Ports:
//   i_clk, i_rstn            clock, asynchronous active-low reset
//   i_fetch_src_pc[1:0]      next-PC select (0 PC+4, 1 PC+IMM, 2 RS1+IMM, 3 PC+4)
//   i_fetch_taken            qualifies select 1; 0 falls back to PC+4
//   i_fetch_imm, i_fetch_rs1 operands for the next-PC adders
//   i_fetch_retire           current instruction complete (honoured in HOLD only)
//   o_fetch_imem_req/addr    instruction-memory request and byte address
//   i_fetch_imem_ack/rdata   instruction-memory response
//   o_fetch_valid            o_fetch_instr / o_fetch_pc hold a valid instruction
//   o_fetch_instr, o_fetch_pc, o_fetch_pc_4
//   o_fetch_misalign         sticky: misaligned target computed, fetch halted
//   o_fetch_retire_cnt       retired instruction count (wraps)
//   o_dbg_state              current FSM state (0 BOOT, 1 REQ, 2 HOLD, 3 HALT)
//
// Memory handshake: req is high for the whole REQ state and addr is held
// equal to the PC; the request completes on the first rising edge where ack
// is high while req is high. An ack seen while req is low is ignored.
module riscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [1:0]  i_fetch_src_pc,
    input  logic        i_fetch_taken,
    input  logic [31:0] i_fetch_imm,
    input  logic [31:0] i_fetch_rs1,
    input  logic        i_fetch_retire,
    output logic        o_fetch_imem_req,
    output logic [31:0] o_fetch_imem_addr,
    input  logic        i_fetch_imem_ack,
    input  logic [31:0] i_fetch_imem_rdata,
    output logic        o_fetch_valid,
    output logic [31:0] o_fetch_instr,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_pc_4,
    output logic        o_fetch_misalign,
    output logic [31:0] o_fetch_retire_cnt,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_4_q, pc_4_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] next_pc;

    // Next-PC selection; all sums are modulo 2^32.
    always_comb begin
        next_pc = pc_4_q;
        case (i_fetch_src_pc)
            2'd1: begin
                if (i_fetch_taken) begin
                    next_pc = pc_q + i_fetch_imm;
                end
            end
            2'd2: begin
                // jalr clears bit 0 of the computed target
                next_pc = (i_fetch_rs1 + i_fetch_imm) & 32'hFFFF_FFFE;
            end
            default: begin
                next_pc = pc_4_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_4_d     = pc_4_q;
        instr_d    = instr_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (i_fetch_imem_ack) begin
                    instr_d = i_fetch_imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (i_fetch_retire) begin
                    cnt_d   = cnt_q + 32'd1;
                    valid_d = 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        pc_4_d  = next_pc + 32'd4;
                        state_d = ST_REQ;
                    end else begin
                        // PC keeps the retiring instruction's address for debug
                        misalign_d = 1'b1;
                        state_d    = ST_HALT;
                    end
                end
            end
            default: begin
                // HALT: only reset leaves this state
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pc_4_q     <= RESET_PC + 32'd4;
            instr_q    <= NOP_INSTR;
            cnt_q      <= 32'd0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_4_q     <= pc_4_d;
            instr_q    <= instr_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Request decoded from registered state only; reset drops it at once.
    assign o_fetch_imem_req   = (state_q == ST_REQ);
    assign o_fetch_imem_addr  = pc_q;
    assign o_fetch_valid      = valid_q;
    assign o_fetch_instr      = instr_q;
    assign o_fetch_pc         = pc_q;
    assign o_fetch_pc_4       = pc_4_q;
    assign o_fetch_misalign   = misalign_q;
    assign o_fetch_retire_cnt = cnt_q;
    assign o_dbg_state        = state_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// Testbench for riscv_fetch: directed fetch/retire sequences with a memory
// responder; expected {pc, instr, pc_4} tuples are queued when each fetch is
// issued and popped by a monitor whenever o_fetch_valid rises.
module tb_riscv_fetch;

  logic        i_clk;
  logic        i_rstn;
  logic [1:0]  i_fetch_src_pc;
  logic        i_fetch_taken;
  logic [31:0] i_fetch_imm;
  logic [31:0] i_fetch_rs1;
  logic        i_fetch_retire;
  logic        o_fetch_imem_req;
  logic [31:0] o_fetch_imem_addr;
  logic        i_fetch_imem_ack;
  logic [31:0] i_fetch_imem_rdata;
  logic        o_fetch_valid;
  logic [31:0] o_fetch_instr;
  logic [31:0] o_fetch_pc;
  logic [31:0] o_fetch_pc_4;
  logic        o_fetch_misalign;
  logic [31:0] o_fetch_retire_cnt;
  logic [1:0]  o_dbg_state;

  int checks = 0;
  int errors = 0;

  logic [95:0] exp_q[$];
  logic        valid_prev = 1'b0;

  riscv_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk              (i_clk),
    .i_rstn             (i_rstn),
    .i_fetch_src_pc     (i_fetch_src_pc),
    .i_fetch_taken      (i_fetch_taken),
    .i_fetch_imm        (i_fetch_imm),
    .i_fetch_rs1        (i_fetch_rs1),
    .i_fetch_retire     (i_fetch_retire),
    .o_fetch_imem_req   (o_fetch_imem_req),
    .o_fetch_imem_addr  (o_fetch_imem_addr),
    .i_fetch_imem_ack   (i_fetch_imem_ack),
    .i_fetch_imem_rdata (i_fetch_imem_rdata),
    .o_fetch_valid      (o_fetch_valid),
    .o_fetch_instr      (o_fetch_instr),
    .o_fetch_pc         (o_fetch_pc),
    .o_fetch_pc_4       (o_fetch_pc_4),
    .o_fetch_misalign   (o_fetch_misalign),
    .o_fetch_retire_cnt (o_fetch_retire_cnt),
    .o_dbg_state        (o_dbg_state)
  );

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " req"},      {31'd0, o_fetch_imem_req}, 32'd0);
    check({tag, " valid"},    {31'd0, o_fetch_valid}, 32'd0);
    check({tag, " instr"},    o_fetch_instr, 32'h0000_0013);
    check({tag, " pc"},       o_fetch_pc, 32'h0);
    check({tag, " pc_4"},     o_fetch_pc_4, 32'h4);
    check({tag, " misalign"}, {31'd0, o_fetch_misalign}, 32'd0);
    check({tag, " cnt"},      o_fetch_retire_cnt, 32'd0);
    check({tag, " state"},    {30'd0, o_dbg_state}, 32'd0);
  endtask

  // driver: serve one fetch with wait_n wait cycles; optionally pulse retire
  // during the wait cycles (must be ignored outside HOLD)
  task automatic do_fetch(input int wait_n, input logic [31:0] exp_addr,
                          input logic [31:0] data, input bit retire_in_wait);
    int guard = 0;
    while (!o_fetch_imem_req && guard < 20) begin
      tick();
      guard++;
    end
    check("req_seen", {31'd0, o_fetch_imem_req}, 32'd1);
    check("req_addr", o_fetch_imem_addr, exp_addr);
    exp_q.push_back({exp_addr, data, exp_addr + 32'd4});
    for (int k = 0; k < wait_n; k++) begin
      i_fetch_retire = retire_in_wait;
      tick();
      i_fetch_retire = 1'b0;
      check("wait_req_held", {31'd0, o_fetch_imem_req}, 32'd1);
      check("wait_addr_held", o_fetch_imem_addr, exp_addr);
    end
    i_fetch_imem_ack   = 1'b1;
    i_fetch_imem_rdata = data;
    tick();
    i_fetch_imem_ack   = 1'b0;
    i_fetch_imem_rdata = $urandom;
    check("valid_after_ack", {31'd0, o_fetch_valid}, 32'd1);
    check("req_low_in_hold", {31'd0, o_fetch_imem_req}, 32'd0);
  endtask

  task automatic do_retire(input logic [1:0] src, input logic taken,
                           input logic [31:0] imm, input logic [31:0] rs1);
    i_fetch_src_pc = src;
    i_fetch_taken  = taken;
    i_fetch_imm    = imm;
    i_fetch_rs1    = rs1;
    i_fetch_retire = 1'b1;
    tick();
    i_fetch_retire = 1'b0;
    i_fetch_src_pc = 2'($urandom_range(0, 3));
    i_fetch_taken  = 1'($urandom_range(0, 1));
    i_fetch_imm    = $urandom;
    i_fetch_rs1    = $urandom;
  endtask

  // scoreboard monitor
  always @(negedge i_clk) begin
    if (o_fetch_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: pc %h instr %h", o_fetch_pc, o_fetch_instr);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        check("mon_pc",    o_fetch_pc,    e[95:64]);
        check("mon_instr", o_fetch_instr, e[63:32]);
        check("mon_pc_4",  o_fetch_pc_4,  e[31:0]);
      end
    end
    valid_prev <= o_fetch_valid;
  end

  initial begin
    i_rstn = 1'b0;
    i_fetch_src_pc = 2'd0;
    i_fetch_taken = 1'b0;
    i_fetch_imm = 32'd0;
    i_fetch_rs1 = 32'd0;
    i_fetch_retire = 1'b0;
    i_fetch_imem_ack = 1'b0;
    i_fetch_imem_rdata = 32'd0;
    tick();
    tick();
    check_reset_values("rst");

    // release: BOOT for one cycle, request to 0x0 on the second
    i_rstn = 1'b1;
    check("boot_req_low", {31'd0, o_fetch_imem_req}, 32'd0);
    tick();
    check("boot_to_req", {30'd0, o_dbg_state}, 32'd1);
    do_fetch(0, 32'h0, 32'h0000_0013, 1'b0);
    check("cnt_before_retire", o_fetch_retire_cnt, 32'd0);
    do_retire(2'd0, 1'b0, 32'h0, 32'h0);
    check("cnt_after_retire", o_fetch_retire_cnt, 32'd1);

    // 3 wait cycles, retire pulsed while not valid
    do_fetch(3, 32'h4, 32'h00A0_0093, 1'b1);
    check("cnt_ignored_retire", o_fetch_retire_cnt, 32'd1);
    check("pc_ignored_retire", o_fetch_pc, 32'h4);

    // jump to 0x100 via rs1+imm
    do_retire(2'd2, 1'b0, 32'h0, 32'h100);
    do_fetch(0, 32'h100, 32'hFF01_0113, 1'b0);
    // select 1, not taken -> PC+4
    do_retire(2'd1, 1'b0, 32'hFFFF_FFF0, 32'h0);
    do_fetch(1, 32'h104, 32'hFE00_08E3, 1'b0);
    // select 1, taken -> PC+imm
    do_retire(2'd1, 1'b1, 32'hFFFF_FFF0, 32'h0);
    do_fetch(0, 32'hF4, 32'h0000_8067, 1'b0);
    // jalr clears bit 0
    do_retire(2'd2, 1'b0, 32'h0, 32'h201);
    do_fetch(2, 32'h200, 32'h1234_5037, 1'b0);
    check("pc_4_at_200", o_fetch_pc_4, 32'h204);
    // reserved select -> PC+4 even with taken
    do_retire(2'd3, 1'b1, 32'h40, 32'h0);
    do_fetch(0, 32'h204, 32'h0040_006F, 1'b0);
    // PC+imm wraps modulo 2^32
    do_retire(2'd1, 1'b1, 32'hFFFF_FE00, 32'h0);
    do_fetch(0, 32'h4, 32'h0020_0093, 1'b0);
    check("cnt_7", o_fetch_retire_cnt, 32'd7);

    // misaligned target -> HALT
    do_retire(2'd2, 1'b0, 32'h0, 32'h202);
    check("misalign_set", {31'd0, o_fetch_misalign}, 32'd1);
    check("halt_state", {30'd0, o_dbg_state}, 32'd3);
    check("halt_req", {31'd0, o_fetch_imem_req}, 32'd0);
    check("halt_valid", {31'd0, o_fetch_valid}, 32'd0);
    check("halt_pc", o_fetch_pc, 32'h4);
    check("halt_cnt", o_fetch_retire_cnt, 32'd8);
    i_fetch_imem_ack = 1'b1;
    i_fetch_imem_rdata = 32'hDEAD_BEEF;
    i_fetch_retire = 1'b1;
    tick();
    tick();
    i_fetch_imem_ack = 1'b0;
    i_fetch_retire = 1'b0;
    check("halt_ack_ignored", o_fetch_instr, 32'h0020_0093);
    check("halt_still_invalid", {31'd0, o_fetch_valid}, 32'd0);
    check("halt_cnt_stable", o_fetch_retire_cnt, 32'd8);
    check("halt_sticky", {31'd0, o_fetch_misalign}, 32'd1);
    check("halt_no_req", {31'd0, o_fetch_imem_req}, 32'd0);

    // reset asserted mid-request; ack arrives a cycle later
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
    tick();
    check("restart_req", {31'd0, o_fetch_imem_req}, 32'd1);
    #2;
    i_rstn = 1'b0;
    #1;
    check("async_req_drop", {31'd0, o_fetch_imem_req}, 32'd0);
    tick();
    i_fetch_imem_ack = 1'b1;
    i_fetch_imem_rdata = 32'hCAFE_F00D;
    tick();
    i_fetch_imem_ack = 1'b0;
    check_reset_values("midrst");
    i_rstn = 1'b1;
    tick();
    do_fetch(0, 32'h0, 32'h0050_0113, 1'b0);
    tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
